// File: rtl/chacha_pkg.sv
// Shared ChaCha definitions: sigma constants, default round count,
// word helpers and the core FSM state type.
package chacha_pkg;

  localparam logic [31:0] SIGMA0 = 32'h61707865;
  localparam logic [31:0] SIGMA1 = 32'h3320646e;
  localparam logic [31:0] SIGMA2 = 32'h79622d32;
  localparam logic [31:0] SIGMA3 = 32'h6b206574;

  localparam int ROUNDS_DEFAULT = 20;

  // Sixteen 32-bit state words, word i at index i.
  typedef logic [15:0][31:0] words_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUNDS,
    ST_FINAL
  } state_t;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [31:0] rotl32(
    input logic [31:0] w,
    input int          n
  );
    return (w << n) | (w >> (32 - n));
  endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter-round.
// Ports: a..d = input words, a_next..d_next = transformed words.
module chacha_qr
  import chacha_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] a_next,
  output logic [31:0] b_next,
  output logic [31:0] c_next,
  output logic [31:0] d_next
);

  logic [31:0] a1, b1, c1, d1;
  logic [31:0] a2, b2, c2, d2;

  assign a1 = a + b;
  assign d1 = rotl32(d ^ a1, 16);
  assign c1 = c + d1;
  assign b1 = rotl32(b ^ c1, 12);

  assign a2 = a1 + b1;
  assign d2 = rotl32(d1 ^ a2, 8);
  assign c2 = c1 + d2;
  assign b2 = rotl32(b1 ^ c2, 7);

  assign a_next = a2;
  assign b_next = b2;
  assign c_next = c2;
  assign d_next = d2;

endmodule

// File: rtl/chacha_cipher_core.sv
// ChaCha block engine: one round per clock, XORs keystream onto data_in.
// Ports: clk, reset_n (sync, active-high), init/next pulses,
// key/ctr/iv/data_in inputs; ready, data_out, data_out_valid outputs.
module chacha_cipher_core
  import chacha_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT
)
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic         next,
  input  logic [255:0] key,
  input  logic [63:0]  ctr,
  input  logic [63:0]  iv,
  input  logic [511:0] data_in,
  output logic         ready,
  output logic [511:0] data_out,
  output logic         data_out_valid
);

  localparam int CW = $clog2(ROUNDS);
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

  state_t          state;
  words_t          init_state;
  words_t          work_state;
  words_t          start_words;
  words_t          round_words;
  logic [CW-1:0]   round_cnt;
  logic            diag;
  logic [63:0]     ctr_inc;
  logic [511:0]    final_block;

  logic [31:0] qa [4];
  logic [31:0] qb [4];
  logic [31:0] qc [4];
  logic [31:0] qd [4];
  logic [31:0] ra [4];
  logic [31:0] rb [4];
  logic [31:0] rc [4];
  logic [31:0] rd [4];

  // Word index for lane (a=0..d=3) of quarter-round k. Diagonal
  // rounds shift each lane's column by the lane number.
  function automatic logic [3:0] widx(
    input logic [1:0] lane,
    input logic [1:0] k,
    input logic       dg
  );
    logic [1:0] col;
    col = dg ? 2'(k + lane) : k;
    return {lane, col};
  endfunction

  assign diag    = round_cnt[0];
  assign ctr_inc = {init_state[13], init_state[12]} + 64'd1;

  always_comb begin
    start_words    = '0;
    start_words[0] = SIGMA0;
    start_words[1] = SIGMA1;
    start_words[2] = SIGMA2;
    start_words[3] = SIGMA3;
    for (int k = 0; k < 8; k++) begin
      start_words[4+k] = bswap32(key[255-32*k -: 32]);
    end
    start_words[12] = ctr[31:0];
    start_words[13] = ctr[63:32];
    start_words[14] = bswap32(iv[63:32]);
    start_words[15] = bswap32(iv[31:0]);
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      qa[k] = work_state[widx(2'd0, 2'(k), diag)];
      qb[k] = work_state[widx(2'd1, 2'(k), diag)];
      qc[k] = work_state[widx(2'd2, 2'(k), diag)];
      qd[k] = work_state[widx(2'd3, 2'(k), diag)];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_qr
    chacha_qr u_qr (
      .a      (qa[g]),
      .b      (qb[g]),
      .c      (qc[g]),
      .d      (qd[g]),
      .a_next (ra[g]),
      .b_next (rb[g]),
      .c_next (rc[g]),
      .d_next (rd[g])
    );
  end

  always_comb begin
    round_words = work_state;
    for (int k = 0; k < 4; k++) begin
      round_words[widx(2'd0, 2'(k), diag)] = ra[k];
      round_words[widx(2'd1, 2'(k), diag)] = rb[k];
      round_words[widx(2'd2, 2'(k), diag)] = rc[k];
      round_words[widx(2'd3, 2'(k), diag)] = rd[k];
    end
  end

  // Word 0 lands in the top 32 bits, each word serialised little-endian.
  always_comb begin
    final_block = '0;
    for (int i = 0; i < 16; i++) begin
      final_block[511-32*i -: 32] =
        data_in[511-32*i -: 32] ^
        bswap32(work_state[i] + init_state[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state          <= ST_IDLE;
      ready          <= 1'b1;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      init_state     <= '0;
      work_state     <= '0;
      round_cnt      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (init) begin
            init_state     <= start_words;
            data_out_valid <= 1'b0;
          end else if (next) begin
            work_state     <= init_state;
            round_cnt      <= '0;
            data_out_valid <= 1'b0;
            ready          <= 1'b0;
            state          <= ST_ROUNDS;
          end
        end
        ST_ROUNDS: begin
          work_state <= round_words;
          if (round_cnt == LAST) begin
            state <= ST_FINAL;
          end else begin
            round_cnt <= round_cnt + 1'b1;
          end
        end
        ST_FINAL: begin
          data_out       <= final_block;
          data_out_valid <= 1'b1;
          ready          <= 1'b1;
          init_state[12] <= ctr_inc[31:0];
          init_state[13] <= ctr_inc[63:32];
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_cipher_core.sv
// Scoreboard bench for chacha_cipher_core: directed blocks, expected
// data from known vectors and a byte-oriented reference model.
module tb_chacha_cipher_core;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         init;
  logic         next;
  logic [255:0] key;
  logic [63:0]  ctr;
  logic [63:0]  iv;
  logic [511:0] data_in;
  logic         ready;
  logic [511:0] data_out;
  logic         data_out_valid;

  chacha_cipher_core #(.ROUNDS(20)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .init           (init),
    .next           (next),
    .key            (key),
    .ctr            (ctr),
    .iv             (iv),
    .data_in        (data_in),
    .ready          (ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [511:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [511:0] ZERO_VEC = {
    256'h76b8e0ada0f13d90405d6ae55386bd28bdd219b8a08ded1aa836efcc8b770dc7,
    256'hda41597c5157488d7724e03fb8d84a376a43b8f41518a11cc387b669b2ee6586
  };
  localparam logic [255:0] K3  = {4{64'h0123456789abcdef}};
  localparam logic [63:0]  IV3 = 64'hdeadbeefcafebabe;

  int qi [8][4] = '{
    '{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
    '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}
  };

  function automatic logic [31:0] le32(input logic [31:0] src);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = src[31-8*j -: 8];
    return w;
  endfunction

  function automatic logic [127:0] qrm(
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] c, input logic [31:0] d
  );
    a = a + b; d = d ^ a; d = (d << 16) | (d >> 16);
    c = c + d; b = b ^ c; b = (b << 12) | (b >> 20);
    a = a + b; d = d ^ a; d = (d << 8) | (d >> 24);
    c = c + d; b = b ^ c; b = (b << 7) | (b >> 25);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] model_ks(
    input logic [255:0] k, input logic [63:0] c, input logic [63:0] n
  );
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [31:0]  w;
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e;
    s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = le32(k[255-32*i -: 32]);
    s[12] = c[31:0];
    s[13] = c[63:32];
    s[14] = le32(n[63:32]);
    s[15] = le32(n[31:0]);
    x = s;
    for (int rr = 0; rr < 20; rr++) begin
      for (int q = 0; q < 4; q++) begin
        int t;
        t = (rr % 2) * 4 + q;
        {x[qi[t][0]], x[qi[t][1]], x[qi[t][2]], x[qi[t][3]]} =
          qrm(x[qi[t][0]], x[qi[t][1]], x[qi[t][2]], x[qi[t][3]]);
      end
    end
    r = '0;
    for (int i = 0; i < 16; i++) begin
      w = x[i] + s[i];
      for (int j = 0; j < 4; j++) r[511-32*i-8*j -: 8] = w[8*j +: 8];
    end
    return r;
  endfunction

  task automatic check(
    input string name, input logic [511:0] got, input logic [511:0] want
  );
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input logic [511:0] d);
    exp_t e;
    e.name = name;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pulse_init();
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  // mode 1 pulses init+next with a different key while busy.
  task automatic run_block(
    input string name, input int mode, output logic [511:0] result
  );
    int n;
    next = 1'b1;
    tick();
    next = 1'b0;
    check({name, "_valid_drop"}, 512'(data_out_valid), 512'd0);
    check({name, "_busy"}, 512'(ready), 512'd0);
    n = 0;
    while (!data_out_valid && n < 40) begin
      if (mode == 1 && n == 5) begin
        init = 1'b1;
        next = 1'b1;
        key  = ~key;
      end
      tick();
      init = 1'b0;
      next = 1'b0;
      n++;
    end
    check({name, "_latency"}, 512'(n), 512'd21);
    check({name, "_ready"}, 512'(ready), 512'd1);
    result = data_out;
  endtask

  // Monitor: compares on every rising edge of data_out_valid.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (data_out_valid && !prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_block got %h want none", data_out);
        end else begin
          e = exp_q.pop_front();
          check(e.name, data_out, e.data);
        end
      end
      prev = data_out_valid;
    end
  end

  initial begin
    logic [511:0] r;
    logic [511:0] outs [10];
    logic [511:0] pt;
    logic [255:0] k2;

    reset_n = 1'b1;
    init    = 1'b0;
    next    = 1'b0;
    key     = '0;
    ctr     = '0;
    iv      = '0;
    data_in = '0;
    repeat (3) tick();
    check("rst_ready", 512'(ready), 512'd1);
    check("rst_valid", 512'(data_out_valid), 512'd0);
    check("rst_data", data_out, 512'd0);
    reset_n = 1'b0;
    tick();

    // Zero key/ctr/iv known vector, then the ctr=1 block.
    pulse_init();
    check("init_ready", 512'(ready), 512'd1);
    push("zero_blk0", ZERO_VEC);
    run_block("blk0", 0, r);
    push("zero_blk1", model_ks('0, 64'd1, '0));
    run_block("blk1", 0, r);
    checks++;
    if (r === ZERO_VEC) begin
      errors++;
      $display("FAIL blk1_differs got %h want not block0", r);
    end

    // Counter sweep with patterned data, then decrypt round trip.
    key = K3;
    iv  = IV3;
    for (int b = 0; b < 10; b++) begin
      ctr     = 64'(b);
      data_in = {16{32'hdeadbeef ^ 32'(b)}};
      pulse_init();
      push($sformatf("enc%0d", b), data_in ^ model_ks(K3, 64'(b), IV3));
      run_block($sformatf("enc%0d", b), 0, r);
      outs[b] = r;
    end
    for (int b = 0; b < 10; b++) begin
      ctr     = 64'(b);
      data_in = outs[b];
      pulse_init();
      push($sformatf("dec%0d", b), {16{32'hdeadbeef ^ 32'(b)}});
      run_block($sformatf("dec%0d", b), 0, r);
    end

    // init/next while busy are ignored; state keeps counting.
    key     = K3;
    ctr     = 64'h100;
    pt      = {8{64'h0011223344556677}};
    data_in = pt;
    pulse_init();
    push("busy_ign", pt ^ model_ks(K3, 64'h100, IV3));
    run_block("busy_ign", 1, r);
    push("busy_next", pt ^ model_ks(K3, 64'h101, IV3));
    run_block("busy_next", 0, r);

    // init and next together in IDLE: init only.
    k2   = {8{32'h0f1e2d3c}};
    key  = k2;
    ctr  = 64'd5;
    init = 1'b1;
    next = 1'b1;
    tick();
    init = 1'b0;
    next = 1'b0;
    repeat (3) tick();
    check("both_ready", 512'(ready), 512'd1);
    check("both_valid", 512'(data_out_valid), 512'd0);
    push("both_blk", pt ^ model_ks(k2, 64'd5, IV3));
    run_block("both_blk", 0, r);

    // 64-bit counter wrap.
    key = K3;
    ctr = '1;
    pulse_init();
    push("wrap_max", pt ^ model_ks(K3, '1, IV3));
    run_block("wrap_max", 0, r);
    push("wrap_zero", pt ^ model_ks(K3, 64'd0, IV3));
    run_block("wrap_zero", 0, r);

    // Reset in the middle of the rounds.
    next = 1'b1;
    tick();
    next = 1'b0;
    repeat (7) tick();
    check("mid_busy", 512'(ready), 512'd0);
    reset_n = 1'b1;
    tick();
    reset_n = 1'b0;
    check("mid_rst_ready", 512'(ready), 512'd1);
    check("mid_rst_valid", 512'(data_out_valid), 512'd0);
    check("mid_rst_data", data_out, 512'd0);
    repeat (30) tick();
    check("mid_rst_quiet", 512'(data_out_valid), 512'd0);
    check("sb_drain", 512'(exp_q.size()), 512'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
